terrain_gen: RTL and testbench
==============================

TERRAIN_GEN -- requirements
Module: terrain_gen

Interface
REQ-001 The block SHALL be parameterised as follows:
  - MIN_H, 8'd80, lowest allowed ground row (smallest y).
  - MAX_H, 8'd115, highest allowed ground row (largest y).
  - GROUND_COLOUR, 3'b010, RGB colour used to plot ground pixels.
REQ-002 The block SHALL have the following ports, one per line:
  - CLOCK_50, in, 1, the single clock; all logic runs on its rising edge.
  - resetn, in, 1, reset; asynchronous assert, active low.
  - start, in, 1, single-cycle pulse requesting generation of new terrain.
  - seed, in, 8, LFSR seed captured when start is accepted.
  - query_valid, in, 1, height lookup request.
  - query_x, in, 8, column to look up.
  - height, out, 8, ground row at the queried column.
  - height_valid, out, 1, height is valid this cycle.
  - ready, out, 1, terrain is generated and drawn, and lookups are being served.
  - busy, out, 1, generation or drawing is in progress.
  - vga_x, out, 8, pixel column for the VGA adapter.
  - vga_y, out, 7, pixel row for the VGA adapter.
  - vga_colour, out, 3, pixel colour.
  - vga_plot, out, 1, write strobe for the pixel.

Function
REQ-003 The block SHALL hold a 160-entry by 8-bit height table in internal registers.
REQ-004 The FSM SHALL have four states: IDLE, GEN, DRAW and READY.
REQ-005 A start pulse SHALL move the FSM from IDLE or READY to GEN on the next edge.
REQ-006 A start pulse during GEN or DRAW SHALL be ignored.
REQ-007 On accepting start, the block SHALL load the LFSR with seed, substituting 8'h01 when seed is 8'h00.
REQ-008 On accepting start, the block SHALL clear the column counter to 0 and clear ready.
REQ-009 The LFSR SHALL be an 8-bit Galois LFSR using feedback mask 8'hB8, advanced once per GEN cycle.
REQ-010 GEN SHALL write exactly one column per cycle for columns 0 to 159, so GEN lasts 160 cycles.
REQ-011 Column 0 SHALL be set to (MIN_H+MAX_H)/2, truncated; 97 with the default parameters.
REQ-012 Each column n>0 SHALL be derived from column n-1 using the current LFSR[1:0]:
  - 2'b00: previous height minus 1.
  - 2'b11: previous height plus 1.
  - otherwise: unchanged.
REQ-013 Each computed column height SHALL be clamped to the range [MIN_H, MAX_H].
REQ-014 After column 159 the FSM SHALL enter DRAW, with the pixel column at 0 and the pixel row at height[0].
REQ-015 DRAW SHALL plot one pixel per cycle with vga_plot=1 and vga_colour=GROUND_COLOUR.
REQ-016 DRAW SHALL scan rows from height[x] to 119 inclusive, then advance to column x+1 starting at row height[x+1].
REQ-017 The DRAW sequence SHALL cover x from 0 to 159.
REQ-018 DRAW SHALL last exactly the sum over x of (120 - height[x]) cycles.
REQ-019 After the last pixel (x=159, y=119) the FSM SHALL enter READY, where ready=1.
REQ-020 vga_plot SHALL be 0 in every cycle outside DRAW.
REQ-021 vga_x, vga_y and vga_colour SHALL be 0 whenever vga_plot is 0.
REQ-022 busy SHALL be 1 exactly in GEN and DRAW.
REQ-023 In READY, query_valid SHALL produce height_valid=1 on the following cycle.
REQ-024 The response height SHALL be height[query_x] for query_x < 160, and 8'd120 (no ground) for query_x >= 160.
REQ-025 Queries SHALL be accepted every cycle, fully pipelined with 1-cycle latency.
REQ-026 A query presented while not in READY SHALL produce height_valid=0 and height=0.
REQ-027 If query_valid and start arrive in the same READY cycle, the query SHALL be answered from the old table and the FSM SHALL still enter GEN.
REQ-028 All counter comparisons SHALL be exact equality against 159 and 119, so no column or row ever wraps past the screen.

Reset
REQ-029 While resetn=0, the FSM SHALL be in IDLE.
REQ-030 While resetn=0, ready, busy, height_valid and vga_plot SHALL be 0.
REQ-031 While resetn=0, height, vga_x, vga_y and vga_colour SHALL be 0.
REQ-032 While resetn=0, the LFSR SHALL hold 8'h01 and all counters SHALL be 0.
REQ-033 The height table contents SHALL be undefined after reset and SHALL NOT be served until READY.
REQ-034 Reset asserted mid-GEN or mid-DRAW SHALL abort immediately.
REQ-035 After such an abort, the block SHALL stay in IDLE until the next start pulse.

Verification
REQ-036 The bench SHALL cover at least these five directed scenarios:
  - Seed 8'h00: start with seed=8'h00 -> GEN behaves identically to seed=8'h01; height[0]=97; busy high from the next cycle.
  - Timing: start with seed=8'hA5 -> busy for exactly 160 + sum(120-height[x]) cycles; then ready=1; plot count equals the DRAW cycle count; no pixel has y<height[x].
  - Clamp: override MIN_H=MAX_H=100 -> every column is 100; DRAW lasts 160*20=3200 cycles.
  - Queries: in READY, query_x=0 then 200 on consecutive cycles -> height 97 then 120, each with height_valid one cycle later; a query during GEN gives height_valid=0.
  - Reset abort: resetn pulsed low at GEN column 50 -> all outputs 0 at once; a later start runs a full, correct generation.

Source files
------------

// File: rtl/terrain_gen.sv
// Purpose: generates a random-walk ground profile (160 columns) from an 8-bit Galois LFSR,
//          plots it pixel-by-pixel to a VGA adapter, then serves per-column height lookups.
// Ports:   CLOCK_50/resetn (async active-low); start+seed kick off generation;
//          query_valid/query_x -> height/height_valid one cycle later (READY only);
//          ready/busy status; vga_x/vga_y/vga_colour/vga_plot pixel write stream.
// Latency: GEN is 160 cycles, DRAW is sum(120-height[x]) cycles; lookups have 1-cycle latency.
module terrain_gen #(
    parameter logic [7:0] MIN_H         = 8'd80,
    parameter logic [7:0] MAX_H         = 8'd115,
    parameter logic [2:0] GROUND_COLOUR = 3'b010
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       start,
    input  logic [7:0] seed,
    input  logic       query_valid,
    input  logic [7:0] query_x,
    output logic [7:0] height,
    output logic       height_valid,
    output logic       ready,
    output logic       busy,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot
);

    typedef enum logic [1:0] {IDLE, GEN, DRAW, READY} state_t;

    localparam logic [8:0] H_SUM    = {1'b0, MIN_H} + {1'b0, MAX_H};
    localparam logic [7:0] MID_H    = H_SUM[8:1];
    localparam logic [7:0] LAST_COL = 8'd159;
    localparam logic [6:0] LAST_ROW = 7'd119;

    state_t     state_q, state_d;
    logic [7:0] lfsr_q, lfsr_d;
    logic [7:0] col_q, col_d;
    logic [7:0] prev_h_q, prev_h_d;
    logic [7:0] px_q, px_d;
    logic [6:0] py_q, py_d;
    logic       plot_q, plot_d;
    logic [2:0] colour_q, colour_d;
    logic       busy_q, busy_d;
    logic       ready_q, ready_d;
    logic       hv_q, hv_d;
    logic [7:0] h_q, h_d;

    // Height table: no reset, only ever read once a full GEN pass has written it.
    logic [7:0] tab_q [160];
    logic       tab_we;

    logic [7:0]        lfsr_next;
    logic signed [9:0] walk_h;
    logic [7:0]        gen_h;

    // Galois LFSR, right-shifting, feedback mask 0xB8.
    assign lfsr_next = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);

    // Random walk from the previous column; signed arithmetic so a step below
    // zero clamps to MIN_H rather than wrapping past MAX_H.
    always_comb begin
        walk_h = $signed({2'b00, prev_h_q});
        case (lfsr_q[1:0])
            2'b00:   walk_h = $signed({2'b00, prev_h_q}) - 10'sd1;
            2'b11:   walk_h = $signed({2'b00, prev_h_q}) + 10'sd1;
            default: walk_h = $signed({2'b00, prev_h_q});
        endcase
        if (col_q == 8'd0) begin
            gen_h = MID_H;
        end else if (walk_h < $signed({2'b00, MIN_H})) begin
            gen_h = MIN_H;
        end else if (walk_h > $signed({2'b00, MAX_H})) begin
            gen_h = MAX_H;
        end else begin
            gen_h = walk_h[7:0];
        end
    end

    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        col_d    = col_q;
        prev_h_d = prev_h_q;
        px_d     = px_q;
        py_d     = py_q;
        plot_d   = plot_q;
        colour_d = colour_q;
        busy_d   = busy_q;
        ready_d  = ready_q;
        tab_we   = 1'b0;

        // Lookups read the table as it stood before this edge, so a query
        // coinciding with start is answered from the old terrain.
        hv_d = (state_q == READY) && query_valid;
        h_d  = 8'd0;
        if (hv_d) begin
            h_d = (query_x < 8'd160) ? tab_q[query_x] : 8'd120;
        end

        case (state_q)
            IDLE, READY: begin
                if (start) begin
                    state_d = GEN;
                    lfsr_d  = (seed == 8'h00) ? 8'h01 : seed;
                    col_d   = 8'd0;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            GEN: begin
                tab_we   = 1'b1;
                prev_h_d = gen_h;
                lfsr_d   = lfsr_next;
                if (col_q == LAST_COL) begin
                    // Column 0 was written 159 cycles ago, so it is readable now.
                    state_d  = DRAW;
                    col_d    = 8'd0;
                    px_d     = 8'd0;
                    py_d     = tab_q[0][6:0];
                    plot_d   = 1'b1;
                    colour_d = GROUND_COLOUR;
                end else begin
                    col_d = col_q + 8'd1;
                end
            end
            DRAW: begin
                if (py_q == LAST_ROW) begin
                    if (px_q == LAST_COL) begin
                        state_d  = READY;
                        ready_d  = 1'b1;
                        busy_d   = 1'b0;
                        px_d     = 8'd0;
                        py_d     = 7'd0;
                        plot_d   = 1'b0;
                        colour_d = 3'b000;
                    end else begin
                        px_d = px_q + 8'd1;
                        py_d = tab_q[px_q + 8'd1][6:0];
                    end
                end else begin
                    py_d = py_q + 7'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            lfsr_q   <= 8'h01;
            col_q    <= 8'd0;
            prev_h_q <= 8'd0;
            px_q     <= 8'd0;
            py_q     <= 7'd0;
            plot_q   <= 1'b0;
            colour_q <= 3'b000;
            busy_q   <= 1'b0;
            ready_q  <= 1'b0;
            hv_q     <= 1'b0;
            h_q      <= 8'd0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            col_q    <= col_d;
            prev_h_q <= prev_h_d;
            px_q     <= px_d;
            py_q     <= py_d;
            plot_q   <= plot_d;
            colour_q <= colour_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
            hv_q     <= hv_d;
            h_q      <= h_d;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (tab_we) begin
            tab_q[col_q] <= gen_h;
        end
    end

    assign height       = h_q;
    assign height_valid = hv_q;
    assign ready        = ready_q;
    assign busy         = busy_q;
    assign vga_x        = px_q;
    assign vga_y        = py_q;
    assign vga_colour   = colour_q;
    assign vga_plot     = plot_q;

endmodule

// File: tb/tb_terrain_gen.sv
// Bench for terrain_gen: a trace model predicts every output on every cycle for the
// default-parameter instance; directed scenarios add literal checks (seed 0, timing,
// clamped instance, lookups, reset abort, start+query collision).
module tb_terrain_gen;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       resetn = 1'b0;
    logic       start = 1'b0, query_valid = 1'b0;
    logic [7:0] seed = 8'd0, query_x = 8'd0;
    logic [7:0] height, vga_x;
    logic       height_valid, ready, busy, vga_plot;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;

    logic       start2 = 1'b0, query_valid2 = 1'b0;
    logic [7:0] seed2 = 8'd0, query_x2 = 8'd0;
    logic [7:0] height2, vga_x2;
    logic       height_valid2, ready2, busy2, vga_plot2;
    logic [6:0] vga_y2;
    logic [2:0] vga_colour2;

    terrain_gen dut (
        .CLOCK_50(clk), .resetn(resetn), .start(start), .seed(seed),
        .query_valid(query_valid), .query_x(query_x),
        .height(height), .height_valid(height_valid), .ready(ready), .busy(busy),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
    );

    terrain_gen #(.MIN_H(8'd100), .MAX_H(8'd100), .GROUND_COLOUR(3'b010)) dut_clamp (
        .CLOCK_50(clk), .resetn(resetn), .start(start2), .seed(seed2),
        .query_valid(query_valid2), .query_x(query_x2),
        .height(height2), .height_valid(height_valid2), .ready(ready2), .busy(busy2),
        .vga_x(vga_x2), .vga_y(vga_y2), .vga_colour(vga_colour2), .vga_plot(vga_plot2)
    );

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic       plot;
        logic [7:0] x;
        logic [6:0] y;
    } ev_t;

    ev_t exp_q[$];
    int  m_new[160];
    int  m_tab[160];
    bit  m_done = 0, m_busy_cur = 0, m_ready_cur = 0;

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return v[0] ? ((v >> 1) ^ 8'hB8) : (v >> 1);
    endfunction

    // Heights straight from the walk rules: column 0 at the midpoint, then
    // one LFSR draw per column.
    task automatic model_gen(input logic [7:0] sd, input int mn, input int mx);
        logic [7:0] l;
        int h;
        l = (sd == 8'h00) ? 8'h01 : sd;
        h = 0;
        for (int c = 0; c < 160; c++) begin
            if (c == 0) h = (mn + mx) / 2;
            else begin
                if (l[1:0] == 2'b00) h = h - 1;
                else if (l[1:0] == 2'b11) h = h + 1;
                if (h < mn) h = mn;
                if (h > mx) h = mx;
            end
            m_new[c] = h;
            l = lfsr_step(l);
        end
    endtask

    function automatic int draw_len();
        int s = 0;
        for (int c = 0; c < 160; c++) s += 120 - m_new[c];
        return s;
    endfunction

    // Cycle-level compare of the default instance.
    always @(posedge clk) begin
        logic       s_rst, s_start, s_qv;
        logic [7:0] s_seed, s_qx;
        logic [29:0] got, want;
        logic       e_busy, e_ready, e_plot, e_hv;
        logic [7:0] e_x, e_h;
        logic [6:0] e_y;
        ev_t        ev;
        s_rst = resetn; s_start = start; s_seed = seed; s_qv = query_valid; s_qx = query_x;
        #1;
        e_busy = 0; e_ready = 0; e_plot = 0; e_hv = 0; e_x = 0; e_y = 0; e_h = 0;
        if (!s_rst) begin
            exp_q.delete();
            m_done = 0; m_busy_cur = 0; m_ready_cur = 0;
        end else begin
            e_hv = m_ready_cur && s_qv;
            if (e_hv) e_h = (s_qx < 160) ? 8'(m_tab[s_qx]) : 8'd120;
            if (s_start && !m_busy_cur) begin
                model_gen(s_seed, 80, 115);
                m_tab = m_new;
                for (int c = 0; c < 160; c++) exp_q.push_back('0);
                for (int x = 0; x < 160; x++)
                    for (int y = m_new[x]; y < 120; y++)
                        exp_q.push_back({1'b1, 8'(x), 7'(y)});
                m_done = 1;
            end
            if (exp_q.size() > 0) begin
                ev = exp_q.pop_front();
                e_busy = 1; e_plot = ev.plot; e_x = ev.x; e_y = ev.y;
            end else begin
                e_ready = m_done;
            end
            m_busy_cur = e_busy;
            m_ready_cur = e_ready;
        end
        got  = {busy, ready, vga_plot, vga_x, vga_y, vga_colour, height_valid, height};
        want = {e_busy, e_ready, e_plot, e_x, e_y, e_plot ? 3'b010 : 3'b000, e_hv, e_h};
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL trace t=%0t: {busy,ready,plot,x,y,col,hv,h} got %h want %h", $time, got, want);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 20000) begin @(negedge clk); n++; end
        chk("ready_reached", ready, 1);
    endtask

    task automatic run_gen(input logic [7:0] sd, output int nb, output int np);
        start = 1; seed = sd;
        @(negedge clk);
        start = 0;
        nb = 0; np = 0;
        while (busy && nb < 30000) begin
            nb++;
            if (vga_plot) np++;
            @(negedge clk);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nb, np, es, e_old;
        logic [7:0] qxs [7];
        int qe [7];
        int lit [6];
        qxs = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd200};
        qe  = '{97, 96, 95, 95, 96, 97, 120};
        lit = '{97, 96, 95, 95, 96, 97};

        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_plot", vga_plot, 0);
        resetn = 1;
        @(negedge clk);

        // Hand-computed seed-1 walk pins the model.
        model_gen(8'h01, 80, 115);
        for (int i = 0; i < 6; i++) chk("model_seed1", m_new[i], lit[i]);

        // Seed 0 behaves as seed 1.
        start = 1; seed = 8'h00;
        @(negedge clk);
        start = 0;
        chk("busy_next_cycle", busy, 1);
        wait_ready();
        for (int i = 0; i < 7; i++) begin
            query_valid = 1; query_x = qxs[i];
            @(negedge clk);
            chk("query_hv", height_valid, 1);
            chk("query_h", height, qe[i]);
        end
        query_valid = 0;
        @(negedge clk);
        chk("query_idle_hv", height_valid, 0);

        // Timing with seed A5.
        model_gen(8'hA5, 80, 115);
        es = draw_len();
        run_gen(8'hA5, nb, np);
        chk("a5_busy_cycles", nb, 160 + es);
        chk("a5_plot_cycles", np, es);
        chk("a5_ready", ready, 1);

        // Clamped instance: every column 100.
        start2 = 1; seed2 = 8'h5A;
        @(negedge clk);
        start2 = 0;
        nb = 0; np = 0;
        while (busy2 && nb < 30000) begin
            nb++;
            if (vga_plot2) np++;
            if (vga_plot2) chk("clamp_y_min", (vga_y2 >= 7'd100), 1);
            @(negedge clk);
        end
        chk("clamp_busy", nb, 3360);
        chk("clamp_plots", np, 3200);
        chk("clamp_ready", ready2, 1);
        for (int i = 0; i < 3; i++) begin
            query_valid2 = 1; query_x2 = (i == 0) ? 8'd0 : (i == 1) ? 8'd159 : 8'd160;
            @(negedge clk);
            chk("clamp_query", height2, (i == 2) ? 120 : 100);
        end
        query_valid2 = 0;

        // Query during GEN, then reset abort around column 50.
        start = 1; seed = 8'h3C;
        @(negedge clk);
        start = 0;
        repeat (5) @(negedge clk);
        query_valid = 1; query_x = 8'd0;
        @(negedge clk);
        query_valid = 0;
        chk("gen_query_hv", height_valid, 0);
        chk("gen_query_h", height, 0);
        repeat (44) @(negedge clk);
        chk("pre_abort_busy", busy, 1);
        #2 resetn = 0;
        #1;
        chk("abort_outputs", {busy, ready, vga_plot, vga_x, vga_y, vga_colour, height_valid, height}, 0);
        repeat (2) @(negedge clk);
        resetn = 1;
        repeat (10) @(negedge clk);
        chk("abort_stays_idle", {busy, ready}, 0);

        model_gen(8'hA5, 80, 115);
        es = draw_len();
        run_gen(8'hA5, nb, np);
        chk("rerun_busy_cycles", nb, 160 + es);
        chk("rerun_ready", ready, 1);

        // Start and query in the same READY cycle: old table answers.
        e_old = m_tab[4];
        start = 1; seed = 8'h11; query_valid = 1; query_x = 8'd4;
        @(negedge clk);
        start = 0; query_valid = 0;
        chk("collide_hv", height_valid, 1);
        chk("collide_h", height, e_old);
        chk("collide_busy", busy, 1);
        wait_ready();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
